// File: rtl/avli2c_tx_byte_fifo.sv
// avli2c_tx_byte_fifo
// Byte-serialising transmit queue between the Avalon-to-I2C EEPROM bridge and
// the byte-level I2C master. One load cycle may push an optional word-address
// byte plus up to four byte-enabled data lanes; they are compacted into a
// circular byte FIFO and handed out one at a time under a consume pulse.
//
// Optional build macro: AVLI2C_TXFIFO_LEVEL_EN adds level_o (registered count)
// and a sticky underflow_o flag for pops attempted while empty.
module avli2c_tx_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic [7:0]                   address_i,
    input  logic                         address_valid_i,
    input  logic [31:0]                  data_i,
    input  logic [3:0]                   data_valid_i,
    input  logic                         clear_i,
    output logic                         i2c_data_available_o,
    output logic [7:0]                   i2c_data_o,
    input  logic                         i2c_read_data_i,
`ifdef AVLI2C_TXFIFO_LEVEL_EN
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         underflow_o,
`endif
    output logic                         overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             avail_q;

    logic [7:0]       push_byte [5];
    logic [2:0]       push_n;
    logic             pop_w;
    logic             accept_w;
    logic             reject_w;
    logic [CNT_W:0]   free_w;

`ifdef AVLI2C_TXFIFO_LEVEL_EN
    logic             underflow_q, underflow_d;
`endif

    // Pointer advance with explicit wrap; DEPTH need not be a power of two and
    // the offset never exceeds DEPTH, so one conditional subtraction suffices.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] ptr,
                                                  input logic [2:0]       off);
        logic [PTR_W:0] sum;
        sum = {1'b0, ptr} + (PTR_W+1)'(off);
        if (sum >= (PTR_W+1)'(DEPTH))
            sum = sum - (PTR_W+1)'(DEPTH);
        return sum[PTR_W-1:0];
    endfunction

    // Compact address byte and enabled lanes into consecutive push slots.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        for (int i = 0; i < 5; i++) push_byte[i] = 8'h00;
        push_n = 3'd0;
        if (address_valid_i) begin
            push_byte[0] = address_i;
            push_n       = 3'd1;
        end
        for (int k = 0; k < 4; k++) begin
            if (data_valid_i[k]) begin
                push_byte[push_n] = data_i[8*k +: 8];
                push_n            = push_n + 3'd1;
            end
        end
    end

    // Space check and next-state for pointers, count and sticky flags.
    always_comb begin
        pop_w    = i2c_read_data_i && (count_q != '0);
        free_w   = (CNT_W+1)'(DEPTH) - {1'b0, count_q} + (CNT_W+1)'(pop_w);
        accept_w = (push_n != 3'd0) && ((CNT_W+1)'(push_n) <= free_w);
        reject_w = (push_n != 3'd0) && !accept_w;

        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
`ifdef AVLI2C_TXFIFO_LEVEL_EN
        underflow_d = underflow_q;
`endif
        if (clear_i) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
`ifdef AVLI2C_TXFIFO_LEVEL_EN
            underflow_d = 1'b0;
`endif
        end else begin
            if (pop_w)
                rd_ptr_d = wrap_add(rd_ptr_q, 3'd1);
            if (accept_w)
                wr_ptr_d = wrap_add(wr_ptr_q, push_n);
            count_d    = count_q - CNT_W'(pop_w) + (accept_w ? CNT_W'(push_n) : '0);
            overflow_d = overflow_q | reject_w;
`ifdef AVLI2C_TXFIFO_LEVEL_EN
            underflow_d = underflow_q | (i2c_read_data_i && (count_q == '0));
`endif
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            avail_q    <= 1'b0;
`ifdef AVLI2C_TXFIFO_LEVEL_EN
            underflow_q <= 1'b0;
`endif
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            avail_q    <= (count_d != '0);
`ifdef AVLI2C_TXFIFO_LEVEL_EN
            underflow_q <= underflow_d;
`endif
        end
    end

    // Byte storage write: all accepted bytes land at consecutive wrapped slots.
    always_ff @(posedge clock_i) begin
        // NOTE: storage has no reset; its contents are never observed while count is zero.
        if (accept_w && !clear_i) begin
            for (int i = 0; i < 5; i++) begin
                if (3'(i) < push_n)
                    mem[wrap_add(wr_ptr_q, 3'(i))] <= push_byte[i];
            end
        end
    end

    // Head byte is masked to zero whenever the queue is empty.
    always_comb begin
        i2c_data_o = avail_q ? mem[rd_ptr_q] : 8'h00;
    end

    assign i2c_data_available_o = avail_q;
    assign overflow_o           = overflow_q;
`ifdef AVLI2C_TXFIFO_LEVEL_EN
    assign level_o              = count_q;
    assign underflow_o          = underflow_q;
`endif

endmodule

// File: tb/tb_avli2c_tx_byte_fifo.sv
// Self-checking bench for avli2c_tx_byte_fifo (DEPTH = 8).
// Stimulus pushes the hand-computed byte order into a scoreboard queue; a
// monitor pops and compares the head byte whenever a consume pulse is seen.
module tb_avli2c_tx_byte_fifo;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic [7:0]  address_i;
    logic        address_valid_i;
    logic [31:0] data_i;
    logic [3:0]  data_valid_i;
    logic        clear_i;
    logic        i2c_data_available_o;
    logic [7:0]  i2c_data_o;
    logic        i2c_read_data_i;
    logic        overflow_o;
`ifdef AVLI2C_TXFIFO_LEVEL_EN
    logic [3:0]  level_o;
    logic        underflow_o;
`endif

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q [$];

    always #5 clock_i = ~clock_i;

    avli2c_tx_byte_fifo #(.DEPTH(8)) dut (
        .clock_i              (clock_i),
        .reset_i              (reset_i),
        .address_i            (address_i),
        .address_valid_i      (address_valid_i),
        .data_i               (data_i),
        .data_valid_i         (data_valid_i),
        .clear_i              (clear_i),
        .i2c_data_available_o (i2c_data_available_o),
        .i2c_data_o           (i2c_data_o),
        .i2c_read_data_i      (i2c_read_data_i),
`ifdef AVLI2C_TXFIFO_LEVEL_EN
        .level_o              (level_o),
        .underflow_o          (underflow_o),
`endif
        .overflow_o           (overflow_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a consume pulse against a non-empty queue must see
    // the next expected byte at the head.
    always @(negedge clock_i) begin
        if (reset_i && !clear_i && i2c_read_data_i && i2c_data_available_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected: got %0h expected none", i2c_data_o);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (i2c_data_o !== e) begin
                    failures++;
                    $display("FAIL pop_head: got %0h expected %0h", i2c_data_o, e);
                end
            end
        end
    end

    task automatic idle_inputs();
        address_i       = 8'h00;
        address_valid_i = 1'b0;
        data_i          = 32'h0;
        data_valid_i    = 4'h0;
        clear_i         = 1'b0;
        i2c_read_data_i = 1'b0;
    endtask

    // Hold the currently driven inputs for one clock, then return to idle.
    task automatic step();
        @(posedge clock_i);
        #1;
        idle_inputs();
    endtask

    task automatic load(input logic av, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] dv, input logic pop);
        address_valid_i = av;
        address_i       = a;
        data_i          = d;
        data_valid_i    = dv;
        i2c_read_data_i = pop;
        step();
    endtask

    task automatic pops(input int n);
        for (int i = 0; i < n; i++) begin
            i2c_read_data_i = 1'b1;
            step();
        end
    endtask

    task automatic expect_bytes(input logic [39:0] b, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(b[8*i +: 8]);
    endtask

    initial begin
        idle_inputs();
        reset_i = 1'b0;
        #12;
        check("reset_avail", i2c_data_available_o, 0);
        check("reset_data", i2c_data_o, 8'h00);
        check("reset_overflow", overflow_o, 0);
        reset_i = 1'b1;
        @(posedge clock_i); #1;

        // Full 5-byte load, then five pops.
        expect_bytes(40'hDD_CC_BB_AA_3C, 5);
        load(1'b1, 8'h3C, 32'hDDCCBBAA, 4'hF, 1'b0);
        check("full_avail", i2c_data_available_o, 1);
        check("full_head", i2c_data_o, 8'h3C);
        pops(5);
        check("full_drained_avail", i2c_data_available_o, 0);
        check("full_drained_data", i2c_data_o, 8'h00);

        // Sparse lanes 1 and 3 only.
        expect_bytes(40'h44_22, 2);
        load(1'b0, 8'h99, 32'h44332211, 4'b1010, 1'b0);
        check("sparse_head", i2c_data_o, 8'h22);
        pops(1);
        check("sparse_avail_after_one", i2c_data_available_o, 1);
        pops(1);
        check("sparse_avail_after_two", i2c_data_available_o, 0);

        // Overflow: second 5-byte load without pop is dropped whole.
        expect_bytes(40'h05_04_03_02_01, 5);
        load(1'b1, 8'h01, 32'h05040302, 4'hF, 1'b0);
        check("ovf_before", overflow_o, 0);
        load(1'b1, 8'h11, 32'h15141312, 4'hF, 1'b0);
        check("ovf_set", overflow_o, 1);
        check("ovf_head_kept", i2c_data_o, 8'h01);
        // free = 4 with pop: still rejected, pop of 01 still happens.
        load(1'b1, 8'h11, 32'h15141312, 4'hF, 1'b1);
        check("ovf_pop_sticky", overflow_o, 1);
        check("ovf_pop_head", i2c_data_o, 8'h02);
        pops(4);
        check("ovf_drained", i2c_data_available_o, 0);
        check("ovf_still_sticky", overflow_o, 1);

        // Clear, then build count 4 at rd=1, wr=5 and load across the wrap.
        clear_i = 1'b1;
        step();
        check("clear_overflow", overflow_o, 0);
        expect_bytes(40'h35_34_33_32_31, 5);
        load(1'b1, 8'h31, 32'h35343332, 4'hF, 1'b0);
        pops(1);
        expect_bytes(40'h45_44_43_42_41, 5);
        load(1'b1, 8'h41, 32'h45444342, 4'hF, 1'b1);
        check("wrap_no_ovf", overflow_o, 0);
        check("wrap_head", i2c_data_o, 8'h33);
        // Queue now full (8): a single extra byte must be rejected.
        load(1'b0, 8'h00, 32'h000000EE, 4'b0001, 1'b0);
        check("full_reject_ovf", overflow_o, 1);
        pops(8);
        check("wrap_drained", i2c_data_available_o, 0);

        // Clear has priority over load and pop in the same cycle.
        expect_bytes(40'h51, 1);
        load(1'b1, 8'h51, 32'h0, 4'h0, 1'b0);
        check("pre_clear_head", i2c_data_o, 8'h51);
        clear_i = 1'b1;
        load(1'b1, 8'h61, 32'h64636262, 4'hF, 1'b1);
        exp_q.delete();
        check("clear_avail", i2c_data_available_o, 0);
        check("clear_data", i2c_data_o, 8'h00);
        check("clear_ovf", overflow_o, 0);
        step();
        check("clear_nothing_enqueued", i2c_data_available_o, 0);

        // Asynchronous reset with three bytes queued.
        load(1'b1, 8'h61, 32'h00006362, 4'b0011, 1'b0);
        check("prereset_head", i2c_data_o, 8'h61);
        #3;
        reset_i = 1'b0;
        #1;
        check("areset_avail", i2c_data_available_o, 0);
        check("areset_data", i2c_data_o, 8'h00);
        check("areset_ovf", overflow_o, 0);
        @(posedge clock_i); #2;
        reset_i = 1'b1;
        @(posedge clock_i); #1;
        step();
        check("post_reset_avail", i2c_data_available_o, 0);
        expect_bytes(40'h71, 1);
        load(1'b1, 8'h71, 32'h0, 4'h0, 1'b0);
        pops(1);
        check("post_reset_drained", i2c_data_available_o, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avli2c_tx_byte_fifo.md
Name: avli2c_tx_byte_fifo

Overview:
- Byte-serialising transmit queue between the Avalon-to-I2C EEPROM bridge and the byte-level I2C master.
- In one cycle, the bridge loads an optional word-address byte plus up to four byte-enabled data lanes.
- The block compacts these into a circular byte FIFO and presents them to the I2C master one byte at a time, under a consume-pulse handshake.

Parameters:
- DEPTH, 8, number of byte entries; legal range 5..64. One load can push 5 bytes.

Ports:
- clock_i  in  1  clock.
- reset_i  in  1  reset, asynchronous, active-low.
- address_i  in  8  word-address byte to queue.
- address_valid_i  in  1  push address_i this cycle.
- data_i  in  32  data lanes; lane k is data_i[8k+7:8k].
- data_valid_i  in  4  per-lane push enable.
- clear_i  in  1  flush queue and flags.
- i2c_data_available_o  out  1  queue non-empty.
- i2c_data_o  out  8  head byte.
- i2c_read_data_i  in  1  single-cycle pulse: master consumed head byte.
- overflow_o  out  1  sticky, a load was rejected.

Behaviour:
- Reset values:
  - Read pointer, write pointer and count are 0.
  - i2c_data_available_o = 0, i2c_data_o = 8'h00, overflow_o = 0.
  - Storage contents are don't-care.
- Load:
  - A load cycle is any cycle with address_valid_i or any data_valid_i bit set.
  - Push order within one cycle: address byte first (if valid), then data lanes in ascending lane order 0..3, skipping lanes with data_valid_i = 0.
  - Sparse enables compact; for example, 4'b1010 pushes lane1 then lane3.
  - N = address_valid_i + popcount(data_valid_i), range 0..5.
- Pop:
  - i2c_read_data_i while count > 0 removes the head byte.
  - i2c_read_data_i while empty is ignored. No state change.
- Space check:
  - free = DEPTH - count + pop, where pop = 1 if a valid pop occurs in the same cycle.
  - If N <= free, all N bytes are written and count_next = count - pop + N.
  - If N > free, the whole load is dropped (never partial), overflow_o is set on the next cycle, and the pop still occurs.
- Pointers:
  - Width is $clog2(DEPTH); count width is $clog2(DEPTH+1).
  - Each pointer wraps explicitly from DEPTH-1 to 0. DEPTH need not be a power of two.
  - A multi-byte push computes each slot as (wr_ptr + i) mod DEPTH.
- Outputs:
  - i2c_data_available_o = (count != 0), registered.
  - i2c_data_o = storage[rd_ptr] when count != 0, else 8'h00.
  - Latency is one cycle: bytes loaded in cycle T are visible from T+1. A byte popped in T is replaced by the next head in T+1.
- Clear:
  - clear_i empties the queue (pointers and count to 0) and clears overflow_o.
  - clear_i has priority over a load and a pop in the same cycle; both are discarded.
- overflow_o clears only on clear_i or reset.
- Asynchronous reset mid-operation aborts immediately to reset values. No partial bytes are retained.
- No state machine beyond the pointer/count datapath. The bridge sequences clear, load and the I2C command strobe externally.

Optional Feature:
- Macro: AVLI2C_TXFIFO_LEVEL_EN.
- Defined:
  - Adds output level_o, width $clog2(DEPTH+1), equal to the registered count.
  - Adds sticky output underflow_o, set on the cycle after i2c_read_data_i arrives while count == 0, and cleared by clear_i or reset.
- Undefined: neither port exists. Pops while empty are silently ignored and the remaining behaviour is identical.

Test Plan:
- Full load with 5 bytes: address_i = 8'h3C, address_valid_i = 1, data_i = 32'hDDCCBBAA, data_valid_i = 4'hF, one cycle. Then five pops. Expect 8'h3C, AA, BB, CC, DD, then available = 0 and i2c_data_o = 00.
- Sparse lanes: data_valid_i = 4'b1010, data_i = 32'h44332211, no address. Expect 8'h22 then 8'h44; count = 2 after the load.
- Overflow with DEPTH = 8: load 5 bytes, then a second 5-byte load with no pop. Expect overflow_o = 1 and count stays 5. Adding a pop in the same cycle as the second load gives free = 4, so the load is still rejected and count becomes 4.
- Simultaneous pop and load at count = 4: one pop plus a 5-byte load gives free = 5, so the load is accepted and count = 8 with no overflow. The head byte order across the wrap (pointer 7 to 0) is preserved.
- Clear priority: clear_i, load and pop in the same cycle. Expect count = 0, available = 0, overflow_o = 0 next cycle, and nothing enqueued.
- Reset mid-stream: assert reset_i low with 3 bytes queued. Outputs go to reset values immediately; after release, available = 0 until a new load.
